secuenciador_captura: RTL

- FSM that sequences PS/2 scan-code entry into the four capture registers: tens, units, presence and ignition.
- Filters break (F0) and extended (E0) prefixes, arms on the start key, and range-checks each digit per field.
- Supports backspace, escape and an inactivity timeout.
- Sits between the PS/2 receiver (dato/tick) and the 8-bit data registers. Drives their one-hot enables and the system-enable pulse.

---
 rtl/secuenciador_captura.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/secuenciador_captura.sv
// Sequences PS/2 scan codes into the tens/units/presence/ignition capture registers.
// Input strobe: dato is meaningful only in the cycle tick=1; there is no back-pressure.
module secuenciador_captura #(
  parameter logic [7:0] START_CODE     = 8'h5A,
  parameter logic [7:0] ESC_CODE       = 8'h76,
  parameter logic [7:0] BKSP_CODE      = 8'h66,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dato,
  input  logic       tick,
  output logic [3:0] registros,
  output logic       active,
  output logic       busy,
  output logic [2:0] campo,
  output logic       error,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DEC = 3'd1,
    WAIT_UNI = 3'd2,
    WAIT_PRE = 3'd3,
    WAIT_IGN = 3'd4,
    COMMIT   = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic          brk, brk_nx, ext, ext_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    tens, tens_nx;
  logic [3:0]    reg_nx;
  logic          active_nx, error_nx, timeout_nx;
  logic          is_prefix, key, dig_ok, accept;
  logic [3:0]    dig;

  always_comb begin
    dig_ok = 1'b1;
    dig    = 4'd0;
    case (dato)
      8'h45: dig = 4'd0;
      8'h16: dig = 4'd1;
      8'h1E: dig = 4'd2;
      8'h26: dig = 4'd3;
      8'h25: dig = 4'd4;
      8'h2E: dig = 4'd5;
      8'h36: dig = 4'd6;
      8'h3D: dig = 4'd7;
      8'h3E: dig = 4'd8;
      8'h46: dig = 4'd9;
      default: dig_ok = 1'b0;
    endcase
  end

  // A byte following F0 or E0 is the tail of a release/extended sequence and never a key.
  assign is_prefix = tick && (dato == 8'hF0 || dato == 8'hE0);
  assign key       = tick && !is_prefix && !brk && !ext;

  always_comb begin
    case (state)
      WAIT_DEC: accept = dig_ok && (dig <= 4'd3);
      WAIT_UNI: accept = dig_ok && ((tens == 4'd3) ? (dig <= 4'd1) : 1'b1);
      WAIT_PRE,
      WAIT_IGN: accept = dig_ok && (dig <= 4'd1);
      default:  accept = 1'b0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    brk_nx     = brk;
    ext_nx     = ext;
    timer_nx   = '0;
    tens_nx    = tens;
    reg_nx     = 4'b0000;
    active_nx  = 1'b0;
    error_nx   = 1'b0;
    timeout_nx = 1'b0;

    if (tick) begin
      if (dato == 8'hF0)      brk_nx = 1'b1;
      else if (dato == 8'hE0) ext_nx = 1'b1;
      else if (brk || ext) begin
        brk_nx = 1'b0;
        ext_nx = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        if (key && dato == START_CODE) state_nx = WAIT_DEC;
      end
      WAIT_DEC, WAIT_UNI, WAIT_PRE, WAIT_IGN: begin
        timer_nx = timer + TW'(1);
        if (key) begin
          if (dato == ESC_CODE) begin
            state_nx = IDLE;
          end else if (dato == BKSP_CODE) begin
            state_nx = state_t'(state - 3'd1);
          end else if (accept) begin
            state_nx = state_t'(state + 3'd1);
            case (state)
              WAIT_DEC: begin
                reg_nx  = 4'b0001;
                tens_nx = dig;
              end
              WAIT_UNI: reg_nx = 4'b0010;
              WAIT_PRE: reg_nx = 4'b0100;
              default:  reg_nx = 4'b1000;
            endcase
          end else begin
            error_nx = 1'b1;
          end
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          // timer is about to reach TIMEOUT_CYCLES with no key pending
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      COMMIT: begin
        active_nx = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (key || state_nx != state) timer_nx = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      brk       <= 1'b0;
      ext       <= 1'b0;
      timer     <= '0;
      tens      <= 4'd0;
      registros <= 4'b0000;
      active    <= 1'b0;
      error     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      brk       <= brk_nx;
      ext       <= ext_nx;
      timer     <= timer_nx;
      tens      <= tens_nx;
      registros <= reg_nx;
      active    <= active_nx;
      error     <= error_nx;
      timeout   <= timeout_nx;
    end
  end

  assign campo = state;
  assign busy  = (state != IDLE);

endmodule
